// File: rtl/wbck_arb_if.sv
// Write-back bus bundle between the ALU / long-pipe producers and the arbiter.
interface wbck_arb_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          alu_wbck_valid;
   logic          alu_wbck_ready;
   logic          alu_wbck_en;
   logic [AW-1:0] alu_wbck_idx;
   logic [DW-1:0] alu_wbck_dat;

   logic          longp_wbck_valid;
   logic          longp_wbck_ready;
   logic [AW-1:0] longp_wbck_idx;
   logic [DW-1:0] longp_wbck_dat;
   logic          longp_wbck_err;

   logic          wbck_dest_wen;
   logic [AW-1:0] wbck_dest_idx;
   logic [DW-1:0] wbck_dest_dat;
   logic          wbck_err;
   logic [31:0]   wbck_cnt;

   // Arbiter side
   modport slave (
      input  alu_wbck_valid, alu_wbck_en, alu_wbck_idx, alu_wbck_dat,
      input  longp_wbck_valid, longp_wbck_idx, longp_wbck_dat, longp_wbck_err,
      output alu_wbck_ready, longp_wbck_ready,
      output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_err, wbck_cnt
   );

   // Producer / register-file side
   modport master (
      output alu_wbck_valid, alu_wbck_en, alu_wbck_idx, alu_wbck_dat,
      output longp_wbck_valid, longp_wbck_idx, longp_wbck_dat, longp_wbck_err,
      input  alu_wbck_ready, longp_wbck_ready,
      input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, wbck_err, wbck_cnt
   );
endinterface

// File: rtl/wbck_arb.sv
// Write-back arbiter: buffered long-pipe results take priority over the ALU;
// the retired item drives the register-file write port one cycle later.
module wbck_arb #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   wbck_arb_if.slave  bus
);
   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = PW + 1;

   logic [AW-1:0] fifo_idx_q [DEPTH];
   logic [DW-1:0] fifo_dat_q [DEPTH];
   logic          fifo_err_q [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          dest_wen_q, dest_wen_d;
   logic [AW-1:0] dest_idx_q, dest_idx_d;
   logic [DW-1:0] dest_dat_q, dest_dat_d;
   logic          err_q, err_d;
   logic [31:0]   cnt_q, cnt_d;

   logic fifo_empty, enq, deq, alu_take;

   // Handshakes depend on registered occupancy only
   assign fifo_empty            = (count_q == '0);
   assign bus.longp_wbck_ready  = (count_q < CW'(DEPTH));
   assign bus.alu_wbck_ready    = fifo_empty;

   assign enq      = bus.longp_wbck_valid & bus.longp_wbck_ready;
   assign deq      = ~fifo_empty;
   assign alu_take = bus.alu_wbck_valid & fifo_empty;

   // Next-state: FIFO bookkeeping and selection of the retiring item
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      dest_wen_d = 1'b0;
      dest_idx_d = dest_idx_q;
      dest_dat_d = dest_dat_q;
      err_d      = 1'b0;

      if (enq) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (deq) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;

      if (deq) begin
         dest_idx_d = fifo_idx_q[rptr_q];
         dest_dat_d = fifo_dat_q[rptr_q];
         err_d      = fifo_err_q[rptr_q];
         dest_wen_d = ~fifo_err_q[rptr_q] & (fifo_idx_q[rptr_q] != '0);
      end else if (alu_take) begin
         dest_idx_d = bus.alu_wbck_idx;
         dest_dat_d = bus.alu_wbck_dat;
         dest_wen_d = bus.alu_wbck_en & (bus.alu_wbck_idx != '0);
      end

      cnt_d = cnt_q + 32'(dest_wen_d);
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         dest_wen_q <= 1'b0;
         dest_idx_q <= '0;
         dest_dat_q <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         dest_wen_q <= dest_wen_d;
         dest_idx_q <= dest_idx_d;
         dest_dat_q <= dest_dat_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   // FIFO storage; written only on enqueue so a fresh entry is never read the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_idx_q[i] <= '0;
            fifo_dat_q[i] <= '0;
            fifo_err_q[i] <= 1'b0;
         end
      end else if (enq) begin
         fifo_idx_q[wptr_q] <= bus.longp_wbck_idx;
         fifo_dat_q[wptr_q] <= bus.longp_wbck_dat;
         fifo_err_q[wptr_q] <= bus.longp_wbck_err;
      end
   end

   assign bus.wbck_dest_wen = dest_wen_q;
   assign bus.wbck_dest_idx = dest_idx_q;
   assign bus.wbck_dest_dat = dest_dat_q;
   assign bus.wbck_err      = err_q;
   assign bus.wbck_cnt      = cnt_q;
endmodule

// File: tb/tb_wbck_arb.sv
// Bench for wbck_arb: queue-based reference model checked every falling edge,
// plus directed scenarios with literal expectations.
module tb_wbck_arb;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wbck_arb_if #(.DW(DW), .AW(AW)) bus ();

   wbck_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffered long-pipe items as a plain queue
   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] dat;
      logic          err;
   } item_t;

   item_t         mq[$];
   logic          e_ret, e_wen, e_err;
   logic [AW-1:0] e_idx;
   logic [DW-1:0] e_dat;
   logic [31:0]   e_cnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         e_ret = 0; e_wen = 0; e_err = 0; e_idx = '0; e_dat = '0; e_cnt = '0;
         chk("rst_wen", bus.wbck_dest_wen, 0);
         chk("rst_err", bus.wbck_err, 0);
         chk("rst_cnt", bus.wbck_cnt, 0);
      end else begin
         item_t it;
         int    n;
         chk("m_wen", bus.wbck_dest_wen, e_wen);
         chk("m_err", bus.wbck_err, e_err);
         chk("m_cnt", bus.wbck_cnt, e_cnt);
         if (e_ret) begin
            chk("m_idx", bus.wbck_dest_idx, e_idx);
            chk("m_dat", bus.wbck_dest_dat, e_dat);
         end
         chk("m_lp_rdy", bus.longp_wbck_ready, (mq.size() < DEPTH));
         chk("m_alu_rdy", bus.alu_wbck_ready, (mq.size() == 0));
         // advance model by one clock using inputs held for the coming edge
         n = mq.size();
         e_ret = 0; e_wen = 0; e_err = 0;
         if (n > 0) begin
            it    = mq.pop_front();
            e_ret = 1;
            e_idx = it.idx; e_dat = it.dat; e_err = it.err;
            e_wen = !it.err && (it.idx != 0);
         end else if (bus.alu_wbck_valid) begin
            e_ret = 1;
            e_idx = bus.alu_wbck_idx; e_dat = bus.alu_wbck_dat;
            e_wen = bus.alu_wbck_en && (bus.alu_wbck_idx != 0);
         end
         if (bus.longp_wbck_valid && n < DEPTH) begin
            it.idx = bus.longp_wbck_idx; it.dat = bus.longp_wbck_dat; it.err = bus.longp_wbck_err;
            mq.push_back(it);
         end
         if (e_wen) e_cnt = e_cnt + 1;
      end
   end

   // Write log filled by the stimulus side
   logic [AW-1:0] wlog[$];

   task automatic step();
      @(posedge clk);
      #2;
      if (bus.wbck_dest_wen) wlog.push_back(bus.wbck_dest_idx);
   endtask

   task automatic idle();
      bus.alu_wbck_valid   = 0; bus.alu_wbck_en = 0; bus.alu_wbck_idx = '0; bus.alu_wbck_dat = '0;
      bus.longp_wbck_valid = 0; bus.longp_wbck_idx = '0; bus.longp_wbck_dat = '0; bus.longp_wbck_err = 0;
   endtask

   task automatic alu(input logic en, input logic [AW-1:0] idx, input logic [DW-1:0] dat);
      bus.alu_wbck_valid = 1; bus.alu_wbck_en = en; bus.alu_wbck_idx = idx; bus.alu_wbck_dat = dat;
   endtask

   task automatic lp(input logic [AW-1:0] idx, input logic [DW-1:0] dat, input logic err);
      bus.longp_wbck_valid = 1; bus.longp_wbck_idx = idx; bus.longp_wbck_dat = dat; bus.longp_wbck_err = err;
   endtask

   initial begin
      int k;
      logic r;
      rst_n = 0;
      idle();
      #1;
      chk("rst0_wen", bus.wbck_dest_wen, 0);
      chk("rst0_idx", bus.wbck_dest_idx, 0);
      chk("rst0_dat", bus.wbck_dest_dat, 0);
      chk("rst0_cnt", bus.wbck_cnt, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      chk("rel_lp_rdy", bus.longp_wbck_ready, 1);
      chk("rel_alu_rdy", bus.alu_wbck_ready, 1);

      // simple ALU write
      alu(1, 5, 32'h1234); step(); idle();
      chk("alu_wen", bus.wbck_dest_wen, 1);
      chk("alu_idx", bus.wbck_dest_idx, 5);
      chk("alu_dat", bus.wbck_dest_dat, 32'h1234);
      chk("alu_cnt", bus.wbck_cnt, 1);

      // write to index 0 is suppressed
      alu(1, 0, 32'hFFFF); step(); idle();
      chk("x0_wen", bus.wbck_dest_wen, 0);
      chk("x0_cnt", bus.wbck_cnt, 1);

      // consume-only ALU result still shows its index
      alu(0, 6, 32'h66); step(); idle();
      chk("noen_wen", bus.wbck_dest_wen, 0);
      chk("noen_idx", bus.wbck_dest_idx, 6);
      step();
      chk("idle_wen", bus.wbck_dest_wen, 0);

      // simultaneous ALU and long-pipe: ALU first, long-pipe next cycle
      alu(1, 7, 32'h77); lp(3, 32'h33, 0);
      chk("both_alu_rdy0", bus.alu_wbck_ready, 1);
      step(); idle();
      chk("both_wen1", bus.wbck_dest_wen, 1);
      chk("both_idx1", bus.wbck_dest_idx, 7);
      chk("both_alu_rdy1", bus.alu_wbck_ready, 0);
      step();
      chk("both_wen2", bus.wbck_dest_wen, 1);
      chk("both_idx2", bus.wbck_dest_idx, 3);
      chk("both_dat2", bus.wbck_dest_dat, 32'h33);
      chk("both_cnt", bus.wbck_cnt, 3);

      // faulted long-pipe result
      lp(9, 32'h99, 1); step(); idle(); step();
      chk("err_pulse", bus.wbck_err, 1);
      chk("err_wen", bus.wbck_dest_wen, 0);
      chk("err_idx", bus.wbck_dest_idx, 9);
      chk("err_cnt", bus.wbck_cnt, 3);
      step();
      chk("err_end", bus.wbck_err, 0);

      // long-pipe streaming, source holds each item until accepted
      wlog.delete();
      k = 0;
      for (int c = 0; c < 24 && k < 8; c++) begin
         lp(AW'(10 + k), DW'(k * 32'h111), 0);
         r = bus.longp_wbck_ready;
         step();
         if (r) k++;
      end
      idle();
      step(); step();
      chk("strm_accepted", k, 8);
      chk("strm_nwrites", wlog.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < wlog.size()) chk("strm_order", wlog[i], 10 + i);
      end
      chk("strm_cnt", bus.wbck_cnt, 11);

      // reset with work in flight
      lp(21, 32'h2121, 0); step();
      alu(1, 22, 32'h22); lp(23, 32'h2323, 0);
      #1 rst_n = 0;
      #1;
      chk("arst_wen", bus.wbck_dest_wen, 0);
      chk("arst_idx", bus.wbck_dest_idx, 0);
      chk("arst_dat", bus.wbck_dest_dat, 0);
      chk("arst_err", bus.wbck_err, 0);
      chk("arst_cnt", bus.wbck_cnt, 0);
      idle();
      step(); step();
      rst_n = 1;
      chk("arel_lp_rdy", bus.longp_wbck_ready, 1);
      chk("arel_alu_rdy", bus.alu_wbck_ready, 1);
      wlog.delete();
      step(); step(); step();
      chk("arel_nwrites", wlog.size(), 0);
      chk("arel_cnt", bus.wbck_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
